// File: rtl/cocotb_array_pkg.sv
// Shared types for the multi-dimension array packer and its benches.
// Holds the FSM state enum, element/array typedefs and the flat-index
// to (i, j, k) split so every user agrees on element ordering.
package cocotb_array_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_t;

    // Default geometry of the passthrough test design.
    localparam int unsigned TEST_ELEM_W = 1;
    localparam int unsigned TEST_DIM    = 3;

    // Element type at the default width; wider instances carry their own
    // logic [ELEM_W-1:0] since a package cannot be parameterised.
    typedef logic [TEST_ELEM_W-1:0] elem_t;
    typedef elem_t test_arr_t [TEST_DIM-1:0][TEST_DIM-1:0][TEST_DIM-1:0];
    typedef logic [TEST_ELEM_W*TEST_DIM*TEST_DIM*TEST_DIM-1:0] test_flat_t;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] j;
        logic [15:0] k;
    } idx_t;

    // Flat element number -> (i, j, k), k varying fastest.
    function automatic idx_t idx_split(input int unsigned n, input int unsigned dim);
        idx_t r;
        r.i = 16'(n / (dim * dim));
        r.j = 16'((n / dim) % dim);
        r.k = 16'(n % dim);
        return r;
    endfunction

endpackage

// File: rtl/cocotb_array_idx_ctr.sv
// Element counter for the array packer.
// Tracks the number of accepted elements plus the matching (i, j, k)
// digits, so storage can be addressed without dividing by DIM.
// Ports: clk, rst (sync, active-high), clr (frame drained), inc (accept),
//        count (elements so far), i/j/k (address of the next element).
module cocotb_array_idx_ctr
    import cocotb_array_pkg::*;
#(
    parameter int unsigned DIM   = 3,
    parameter int unsigned CNT_W = 5,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic [IDX_W-1:0] k
);

    // Mixed-radix increment; i may step past DIM-1 only on the final
    // element, after which the packer stops writing until clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
            if (k == IDX_W'(DIM - 1)) begin
                k <= '0;
                if (j == IDX_W'(DIM - 1)) begin
                    j <= '0;
                    i <= i + IDX_W'(1);
                end else begin
                    j <= j + IDX_W'(1);
                end
            end else begin
                k <= k + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/cocotb_array_packer.sv
// Collects a valid/ready stream of ELEM_W-bit elements into a
// DIM x DIM x DIM frame and presents it as a 3-level unpacked array and
// as a flat packed vector.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_last
//        element stream; out_valid/out_ready frame handshake; out_arr,
//        out_flat frame views; out_count elements in frame; out_short
//        frame ended early by in_last.
module cocotb_array_packer
    import cocotb_array_pkg::*;
#(
    parameter int unsigned ELEM_W = 1,
    parameter int unsigned DIM    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ELEM_W-1:0]          in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ELEM_W-1:0]          out_arr [DIM-1:0][DIM-1:0][DIM-1:0],
    output logic [DIM*DIM*DIM*ELEM_W-1:0] out_flat,
    output logic [$clog2(DIM*DIM*DIM+1)-1:0] out_count,
    output logic                       out_short
);

    localparam int unsigned N     = DIM * DIM * DIM;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

    packer_state_t    state;
    logic             accept;
    logic             drain;
    logic             last_elem;
    logic [IDX_W-1:0] wi;
    logic [IDX_W-1:0] wj;
    logic [IDX_W-1:0] wk;

    // Ready depends on state and reset only, never on in_valid.
    assign in_ready  = (state == FILL) && !rst;
    assign accept    = in_valid && in_ready;
    assign drain     = (state == HOLD) && out_ready;
    assign last_elem = (out_count == CNT_W'(N - 1));

    cocotb_array_idx_ctr #(
        .DIM   (DIM),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_idx_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (drain),
        .inc   (accept),
        .count (out_count),
        .i     (wi),
        .j     (wj),
        .k     (wk)
    );

    // FSM plus frame storage; storage is cleared whenever a frame leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            out_valid <= 1'b0;
            out_short <= 1'b0;
            for (int a = 0; a < int'(DIM); a++)
                for (int b = 0; b < int'(DIM); b++)
                    for (int c = 0; c < int'(DIM); c++)
                        out_arr[a][b][c] <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        out_arr[wi][wj][wk] <= in_data;
                        if (last_elem || in_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_short <= !last_elem;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        out_short <= 1'b0;
                        for (int a = 0; a < int'(DIM); a++)
                            for (int b = 0; b < int'(DIM); b++)
                                for (int c = 0; c < int'(DIM); c++)
                                    out_arr[a][b][c] <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Packed view: element (i, j, k) sits at flat index (i*DIM + j)*DIM + k.
    for (genvar gi = 0; gi < int'(DIM); gi++) begin : g_i
        for (genvar gj = 0; gj < int'(DIM); gj++) begin : g_j
            for (genvar gk = 0; gk < int'(DIM); gk++) begin : g_k
                assign out_flat[((gi * DIM + gj) * DIM + gk) * ELEM_W +: ELEM_W] =
                    out_arr[gi][gj][gk];
            end
        end
    end

endmodule

// File: doc/cocotb_array_packer.md
Name: cocotb_array_packer

Overview:
- Upstream feeder for the multi-dimension array passthrough test design.
- Collects a serial stream of ELEM_W-bit elements into a DIM x DIM x DIM frame.
- Presents each completed frame two ways: as a 3-level unpacked array and as a flat packed vector.
- Lets cocotb benches drive array ports from a simple valid/ready stream, and exercises sequential handle access on multi-dimensional signals.

Parameters:
- ELEM_W, 1, width of one element in bits (1 = plain logic).
- DIM, 3, extent of every dimension; frame holds N = DIM**3 elements.
- CNT_W, $clog2(DIM**3+1), width of the element counter (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream element valid.
- in_ready  output  1  packer can accept an element.
- in_data  input  ELEM_W  element value.
- in_last  input  1  final element of the frame; qualified by in_valid.
- out_valid  output  1  completed frame available.
- out_ready  input  1  downstream accepts the frame.
- out_arr  output  ELEM_W per element, unpacked [DIM-1:0][DIM-1:0][DIM-1:0]  frame, 3-level unpacked view.
- out_flat  output  N*ELEM_W  same frame, packed view.
- out_count  output  CNT_W  number of elements accepted into the current or presented frame.
- out_short  output  1  presented frame was terminated early by in_last.

Behaviour:
- Reset, synchronous with rst high at a rising edge:
  - state=FILL; storage all 0; out_count=0; out_short=0; out_valid=0.
  - in_ready=0 while rst is high.
- in_ready = (state==FILL) && !rst. It is combinational from the state only and never depends on in_valid.
- Accept = in_valid && in_ready.
- On accept of element number n (n = out_count before the edge):
  - The element is stored at out_arr[i][j][k], with i=n/(DIM*DIM), j=(n/DIM)%DIM, k=n%DIM (k varies fastest).
  - It is also stored at out_flat[n*ELEM_W +: ELEM_W].
  - out_count increments by 1.
- Frame completes on the accept where n==N-1, or on any accept with in_last=1.
  - Next state = HOLD.
  - out_valid=1 from the cycle after the completing accept (latency 1 edge).
  - out_short=1 iff in_last was set with n<N-1.
  - in_last on element N-1 gives out_short=0.
  - Frame completion at n==N-1 does not require in_last.
- HOLD state:
  - in_ready=0.
  - out_arr, out_flat, out_count and out_short are held stable.
  - out_valid stays high until out_valid && out_ready.
- On the out handshake edge:
  - state=FILL; storage cleared to 0; out_count=0; out_short=0; out_valid=0.
  - in_ready rises the following cycle, giving a 1-cycle bubble between frames. No same-cycle bypass.
- Short frames: elements beyond the last accepted one read as 0.
- out_ready high before out_valid is legal and has no effect.
- in_valid low mid-frame: the frame pauses with no timeout, and the count is retained.
- Reset mid-frame or in HOLD: the partial or held frame is discarded, all state returns to reset values, and no out_valid pulse is produced.
- No overflow is possible: the count saturates at N, and HOLD blocks further input.
- FSM has two states, FILL and HOLD; no other states are reachable.

Decomposition:
- The shared package cocotb_array_pkg holds:
  - packer_state_t (FILL, HOLD);
  - a parameterised-width element typedef alongside the existing test array typedefs;
  - the index-split helper function (n -> i, j, k), so benches and RTL agree on ordering.
- Sub-module cocotb_array_idx_ctr: the CNT_W counter with clear/increment and i, j, k outputs.
- Storage and FSM stay in the top-level block.

Test Plan:
- Full frame: after reset, stream 27 elements (ELEM_W=1) with pattern bit n = n%2 and no in_last, out_ready=1 → out_valid high 1 cycle after the 27th accept; out_arr[0][0][1]=1, out_arr[2][2][2]=0; out_flat=27'h2AAAAAA; out_count=27; out_short=0.
- Short frame: 5 elements of value 1, in_last on the 5th → out_count=5, out_short=1; out_arr[0][1][1]=1, out_arr[0][1][2]=0; out_flat=27'h1F.
- Backpressure: complete a frame and hold out_ready=0 for 10 cycles while in_valid=1 → in_ready stays 0, outputs are stable, nothing new is accepted; on out_ready=1 there is one handshake, then in_ready=1 the next cycle.
- Gapped input: in_valid toggles every other cycle across a full frame → same contents as the back-to-back case; out_count steps only on accepts.
- Reset mid-frame: accept 13 elements, assert rst for 1 cycle → out_count=0, out_flat=0, no out_valid; the next 27-element frame is correct.
- ELEM_W=4, DIM=2: stream values 1..8 → out_arr[1][1][1]=8 and out_flat=32'h87654321.
